// File: rtl/sram_byte_sequencer.sv
// sram_byte_sequencer
//
// Turns one 16-bit chipset request into one or two byte cycles on an 8-bit
// asynchronous SRAM (21-bit address, 2 MB). Each byte cycle runs
// SETUP -> ACCESS (WAIT_CYCLES cycles) -> RECOVER. The write strobe
// sram_we_n is low only in ACCESS. Address and data are set up one cycle
// before the strobe falls and held one cycle after it rises.
//
// Configuration macro: SRAM_FAST_READ_EN. When it is defined, read bytes
// skip RECOVER. Writes are the same in both builds.
//
// Handshake: the requester raises req together with we/addr/be/wdata.
// The block samples req only in IDLE, and that sampling edge accepts the
// request. ack is a one-cycle pulse that completes the request. While ack
// is high, rdata holds the read result. A requester that still holds req
// one cycle after ack starts a new access.
//
// Ports:
//   clk, reset_n              clock; asynchronous active-low reset
//   req, we, addr, be, wdata  request side (addr = low byte address)
//   rdata, ack, busy          completion side
//   sram_a, sram_d_o,
//   sram_d_oe, sram_we_n      SRAM pins (all registered)
//   sram_d_i                  SRAM data returned from the pad
module sram_byte_sequencer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [20:0] addr,
    input  logic [1:0]  be,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic [20:0] sram_a,
    output logic [7:0]  sram_d_o,
    output logic        sram_d_oe,
    input  logic [7:0]  sram_d_i,
    output logic        sram_we_n
);

`ifdef SRAM_FAST_READ_EN
    localparam bit FAST_READ = 1'b1;
`else
    localparam bit FAST_READ = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RECOVER,
        S_DONE
    } state_t;

    state_t      state_q;
    logic        we_q;
    logic [20:0] addr_q;
    logic [1:0]  be_q;
    logic [15:0] wdata_q;
    logic        hi_q;       // the current byte cycle is for the high byte
    logic [3:0]  wait_q;     // counts down the remaining ACCESS cycles
    logic [15:0] rdata_q;
    logic        ack_q;
    logic        busy_q;
    logic [20:0] sram_a_q;
    logic [7:0]  sram_d_o_q;
    logic        sram_d_oe_q;
    logic        sram_we_n_q;

    logic [20:0] hi_addr_d;
    logic        more_d;

    // The high byte address wraps naturally at 2^21.
    assign hi_addr_d = addr_q + 21'd1;
    assign more_d    = !hi_q && be_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            hi_q        <= 1'b0;
            wait_q      <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            sram_a_q    <= '0;
            sram_d_o_q  <= '0;
            sram_d_oe_q <= 1'b0;
            sram_we_n_q <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        be_q    <= be;
                        wdata_q <= wdata;
                        busy_q  <= 1'b1;
                        // Clear the lanes so that bytes not enabled read back as 0x00.
                        if (!we && be != 2'b00) rdata_q <= '0;
                        if (be == 2'b00) begin
                            state_q <= S_DONE;
                            ack_q   <= 1'b1;
                        end else begin
                            hi_q        <= !be[0];
                            sram_a_q    <= be[0] ? addr : addr + 21'd1;
                            if (we) sram_d_o_q <= be[0] ? wdata[7:0] : wdata[15:8];
                            sram_d_oe_q <= we;
                            sram_we_n_q <= 1'b1;
                            state_q     <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    wait_q  <= 4'(WAIT_CYCLES - 1);
                    if (we_q) sram_we_n_q <= 1'b0;
                    state_q <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (wait_q == 4'd0) begin
                        sram_we_n_q <= 1'b1;
                        if (!we_q) begin
                            if (hi_q) rdata_q[15:8] <= sram_d_i;
                            else      rdata_q[7:0]  <= sram_d_i;
                        end
                        if (FAST_READ && !we_q) begin
                            // Read bytes need no hold time, so go straight to the next byte.
                            if (more_d) begin
                                hi_q     <= 1'b1;
                                sram_a_q <= hi_addr_d;
                                state_q  <= S_SETUP;
                            end else begin
                                state_q <= S_DONE;
                                ack_q   <= 1'b1;
                            end
                        end else begin
                            state_q <= S_RECOVER;
                        end
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                S_RECOVER: begin
                    if (more_d) begin
                        hi_q     <= 1'b1;
                        sram_a_q <= hi_addr_d;
                        if (we_q) sram_d_o_q <= wdata_q[15:8];
                        state_q  <= S_SETUP;
                    end else begin
                        sram_d_oe_q <= 1'b0;
                        state_q     <= S_DONE;
                        ack_q       <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign sram_a    = sram_a_q;
    assign sram_d_o  = sram_d_o_q;
    assign sram_d_oe = sram_d_oe_q;
    assign sram_we_n = sram_we_n_q;

endmodule

// File: tb/tb_sram_byte_sequencer.sv
// Bench for sram_byte_sequencer. A byte-wide SRAM model answers reads and
// records every completed write pulse. A request-level reference model
// predicts these results for each request: the byte writes in order, the
// read data, and the ack latency.
module tb_sram_byte_sequencer;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic        we;
  logic [20:0] addr;
  logic [1:0]  be;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        busy;
  logic [20:0] sram_a;
  logic [7:0]  sram_d_o;
  logic        sram_d_oe;
  logic [7:0]  sram_d_i;
  logic        sram_we_n;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected and observed byte writes, each entry {addr[20:0], data[7:0]}.
  logic [28:0] exp_q[$];
  logic [28:0] wr_q[$];

  logic [7:0]  sram_mem [logic [20:0]];
  logic [7:0]  ref_mem  [logic [20:0]];
  logic [15:0] exp_rdata;

  sram_byte_sequencer #(.WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .be        (be),
    .wdata     (wdata),
    .rdata     (rdata),
    .ack       (ack),
    .busy      (busy),
    .sram_a    (sram_a),
    .sram_d_o  (sram_d_o),
    .sram_d_oe (sram_d_oe),
    .sram_d_i  (sram_d_i),
    .sram_we_n (sram_we_n)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [20:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] sram_rd(input logic [20:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : init_byte(a);
  endfunction

  // ---------------- SRAM model and strobe timing monitor ----------------
  logic        prev_we_n = 1'b1;
  logic        prev_oe   = 1'b0;
  logic [20:0] prev_a    = '0;
  logic [7:0]  prev_d    = '0;
  int          low_cnt   = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      low_cnt = 0;
    end else begin
      if (!sram_we_n) begin
        if (prev_we_n) begin
          check("setup_addr", 32'(sram_a), 32'(prev_a));
          check("setup_data", 32'(sram_d_o), 32'(prev_d));
          check("setup_oe", 32'(prev_oe), 32'd1);
        end
        check("we_oe", 32'(sram_d_oe), 32'd1);
        low_cnt++;
      end else if (!prev_we_n) begin
        check("pulse_width", 32'(low_cnt), 32'(W));
        check("hold_addr", 32'(sram_a), 32'(prev_a));
        check("hold_data", 32'(sram_d_o), 32'(prev_d));
        check("hold_oe", 32'(sram_d_oe), 32'd1);
        wr_q.push_back({prev_a, prev_d});
        sram_mem[prev_a] = prev_d;
        low_cnt = 0;
      end
    end
    prev_we_n = sram_we_n;
    prev_oe   = sram_d_oe;
    prev_a    = sram_a;
    prev_d    = sram_d_o;
    sram_d_i  = sram_rd(sram_a);
  end

  // ---------------- reference model ----------------
  task automatic model(input logic w, input logic [20:0] a, input logic [1:0] b,
                       input logic [15:0] d, output int lat);
    int n;
    logic [15:0] rd;
    n  = 0;
    rd = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      if (b[i]) begin
        logic [20:0] ba;
        ba = a + 21'(i);
        n++;
        if (w) begin
          exp_q.push_back({ba, d[8*i +: 8]});
          ref_mem[ba] = d[8*i +: 8];
        end else begin
          rd[8*i +: 8] = ref_rd(ba);
        end
      end
    end
    if (!w && n != 0) exp_rdata = rd;
`ifdef SRAM_FAST_READ_EN
    lat = w ? n * (W + 2) : n * (W + 1);
`else
    lat = n * (W + 2);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic present(input logic w, input logic [20:0] a, input logic [1:0] b,
                         input logic [15:0] d);
    req   = 1'b1;
    we    = w;
    addr  = a;
    be    = b;
    wdata = d;
  endtask

  // Call this #1 after the accepting edge. It returns #1 after the DONE->IDLE edge.
  task automatic complete(input string tag, input logic w, input logic [20:0] a,
                          input logic [1:0] b, input logic [15:0] d);
    int exp_lat;
    int lat;
    model(w, a, b, d, exp_lat);
    check({tag, "_busy_accept"}, 32'(busy), 32'd1);
    lat = 0;
    while (!ack && lat < 200) begin
      if (!w) check({tag, "_read_oe"}, 32'(sram_d_oe), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_ack_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    check({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    while (wr_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_wr_byte"}, 32'(wr_q.pop_front()), 32'(exp_q.pop_front()));
    wr_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    check({tag, "_ack_low"}, 32'(ack), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic access(input string tag, input logic w, input logic [20:0] a,
                        input logic [1:0] b, input logic [15:0] d);
    @(negedge clk);
    present(w, a, b, d);
    @(posedge clk); #1;
    req = 1'b0;
    complete(tag, w, a, b, d);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int   t;
    logic ack_seen;
    reset_n   = 1'b0;
    req       = 1'b0;
    we        = 1'b0;
    addr      = '0;
    be        = '0;
    wdata     = '0;
    exp_rdata = '0;

    // Reset values
    #12;
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe", 32'(sram_d_oe), 32'd0);
    check("rst_a", 32'(sram_a), 32'd0);
    check("rst_d_o", 32'(sram_d_o), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Word write, then word read from preloaded bytes
    access("word_write", 1'b1, 21'h012340, 2'b11, 16'hBEEF);
    sram_mem[21'h012340] = 8'h5A; ref_mem[21'h012340] = 8'h5A;
    sram_mem[21'h012341] = 8'hA5; ref_mem[21'h012341] = 8'hA5;
    access("word_read", 1'b0, 21'h012340, 2'b11, 16'h0000);
    check("word_read_value", 32'(rdata), 32'h0000A55A);

    // High-byte write at the top of memory wraps to address 0
    access("wrap_write", 1'b1, 21'h1FFFFF, 2'b10, 16'h7C11);
    access("wrap_read", 1'b0, 21'h1FFFFF, 2'b11, 16'h0000);

    // No bytes enabled
    access("be00_write", 1'b1, 21'h000123, 2'b00, 16'h1234);
    access("be00_read", 1'b0, 21'h000456, 2'b00, 16'h0000);

    // Single-lane reads return 0x00 in the disabled lane
    access("lo_read", 1'b0, 21'h012340, 2'b01, 16'h0000);
    access("hi_read", 1'b0, 21'h012340, 2'b10, 16'h0000);

    // Back-to-back with req held: second accept 2 edges after ack rises
    @(negedge clk);
    present(1'b1, 21'h000010, 2'b11, 16'hC0DE);
    @(posedge clk); #1;
    present(1'b0, 21'h000010, 2'b11, 16'h0000);
    complete("b2b_first", 1'b1, 21'h000010, 2'b11, 16'hC0DE);
    @(posedge clk); #1;
    req = 1'b0;
    complete("b2b_second", 1'b0, 21'h000010, 2'b11, 16'h0000);

    // Reset during the ACCESS phase of a write
    @(negedge clk);
    present(1'b1, 21'h0ABCDE, 2'b11, 16'h5566);
    @(posedge clk); #1;
    req = 1'b0;
    t = 0;
    while (sram_we_n && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("abort_reach_access", 32'(sram_we_n), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_oe", 32'(sram_d_oe), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_a", 32'(sram_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_rdata = '0;
    ack_seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      ack_seen = ack_seen | ack;
    end
    check("abort_no_ack", 32'(ack_seen), 32'd0);
    check("abort_busy_after", 32'(busy), 32'd0);
    check("abort_no_writes", 32'(wr_q.size()), 32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    wr_q.delete();

    // Randomized requests
    for (int k = 0; k < 40; k++) begin
      logic        rw;
      logic [20:0] ra;
      logic [1:0]  rb;
      logic [15:0] rd;
      rw = 1'($urandom_range(0, 1));
      ra = (k % 6 == 0) ? 21'h1FFFFF : 21'($urandom);
      if (k % 4 == 1) ra = 21'h012340 + 21'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      rd = 16'($urandom);
      access("rand", rw, ra, rb, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected test end");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_byte_sequencer.md
# sram_byte_sequencer

Converts 16-bit chipset memory requests into sequences of byte cycles on the board's 8-bit asynchronous SRAM.
- Address bus is 21 bits (2 MB).
- Write enable is the only SRAM strobe driven by the FPGA.

The block sits between the 2 MB system core and the SRAM pins. The top level instantiates the tristate buffer from `sram_d_o`/`sram_d_oe` and feeds the pad back into `sram_d_i`.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: clock cycles per byte access phase (ACCESS state); legal range 1–15.

Ports:
- `clk`  in  1  chipset clock (50 MHz).
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req`  in  1  access request; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; captured with `req`.
- `addr`  in  21  byte address of the low byte; high byte at `addr+1` mod 2^21.
- `be`  in  2  byte enables; bit0 = low byte, bit1 = high byte.
- `wdata`  in  16  write data; [7:0] low byte, [15:8] high byte.
- `rdata`  out  16  read data; valid while `ack`=1, held until the next accepted read.
- `ack`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.
- `sram_a`  out  21  SRAM address.
- `sram_d_o`  out  8  SRAM write data.
- `sram_d_oe`  out  1  SRAM data output enable.
- `sram_d_i`  in  8  SRAM data from pad.
- `sram_we_n`  out  1  SRAM write enable, active-low.

## Operation
- States: IDLE, SETUP, ACCESS, RECOVER, DONE.
- **IDLE, `req`=1:** latch `we`, `addr`, `be`, `wdata`.
  - If `be`=00: go to DONE.
  - Otherwise: select the lowest enabled byte and go to SETUP.
- **SETUP (1 cycle):**
  - `sram_a` = byte address.
  - Write: `sram_d_o` = byte and `sram_d_oe`=1.
  - `sram_we_n`=1.
- **ACCESS (`WAIT_CYCLES` cycles):**
  - Write: `sram_we_n`=0.
  - Read: `sram_we_n`=1, `sram_d_oe`=0, and `sram_d_i` is registered into its `rdata` lane on the last ACCESS edge.
- **RECOVER (1 cycle):**
  - `sram_we_n`=1.
  - `sram_a` and `sram_d_o`/`sram_d_oe` unchanged, giving hold time.
  - Next: SETUP for the high byte if it is enabled and still pending, otherwise DONE.
- **DONE (1 cycle):** `ack`=1, then IDLE.
- Output registering:
  - `sram_a` changes only on entry to SETUP.
  - `sram_we_n` and `sram_d_oe` are registered outputs (no glitches).
- **Reads:**
  - Lanes not enabled return 0x00.
  - `rdata` updates only on reads.
- **Writes:** `rdata` is unchanged.
- `req` asserted outside IDLE is ignored.
  - The requester must drop `req` no later than the cycle after `ack`, or a new access starts.
- Address wrap: a high byte at `addr`=0x1FFFFF goes to 0x000000.

## Timing
- Reset values:
  - `sram_we_n`=1, `sram_d_oe`=0.
  - `sram_a`=0, `sram_d_o`=0.
  - `rdata`=0, `ack`=0, `busy`=0.
  - State = IDLE.
- Reset is asynchronous: assertion mid-write drives `sram_we_n` high and `sram_d_oe` low immediately. The aborted write gets no `ack`.
- Per-byte cost: `WAIT_CYCLES`+2 cycles.
- `ack` latency: `ack` is high in the cycle beginning `n`·(`WAIT_CYCLES`+2) edges after the accepting edge, where `n` = number of enabled bytes.
  - `WAIT_CYCLES`=2, word access: 8 cycles.
  - `be`=00: `ack` in the cycle right after acceptance.
- Back-to-back: with `req` held, the next access is accepted 2 edges after `ack` rises (DONE→IDLE→accept).
- Signal bounds:
  - `busy` rises on the accepting edge and falls on the edge leaving DONE.
  - `sram_we_n` low pulse width equals `WAIT_CYCLES` cycles exactly, with ≥1 cycle of address/data setup and ≥1 cycle of hold.

## Configuration
- Macro: `SRAM_FAST_READ_EN`.
- Defined:
  - Read bytes skip RECOVER (read per-byte cost = `WAIT_CYCLES`+1).
  - Word read latency with `WAIT_CYCLES`=2 is 6 cycles.
  - Writes are unchanged.
- Undefined: all byte cycles include RECOVER as specified above.

## Test plan
- **Word write:** `addr`=0x012340, `be`=11, `wdata`=0xBEEF, `WAIT_CYCLES`=2 → requirements:
  - 0xEF then 0xBE, written at 0x012340 then 0x012341.
  - Each byte: `sram_we_n` low for 2 cycles, with `sram_a` stable 1 cycle before and after.
  - `ack` 8 cycles after accept.
- **Word read:** model returns 0x5A at 0x012340 and 0xA5 at 0x012341 → `rdata`=0xA55A while `ack`=1; `sram_d_oe` stays 0 throughout.
- **High-byte write with wrap:** `addr`=0x1FFFFF, `be`=10 → exactly one write cycle at `sram_a`=0x000000 with `wdata[15:8]`; `ack` 4 cycles after accept.
- **`be`=00:** `ack` 1 cycle after accept; `sram_we_n` never low; `rdata` unchanged.
- **Reset mid-write:** deassert `reset_n` during ACCESS → `sram_we_n`=1 and `sram_d_oe`=0 before the next edge. After release: IDLE, `busy`=0, no `ack`.
- **Back-to-back and fast read:**
  - `req` held high: second access accepted 2 edges after `ack`.
  - With `SRAM_FAST_READ_EN`: word read `ack` 6 cycles after accept.
